// File: rtl/cv32e40p_fpu_arbiter.sv
// ============================================================================
// cv32e40p_fpu_arbiter -- round-robin sharing of one FPNEW-style FPU among
// NUM_REQ requesters, with an in-order ID FIFO for result routing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cv32e40p_fpu_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int DEPTH    = 4,
   parameter int OP_BITS  = 5,
   parameter int FMT_BITS = 3,
   parameter int WIDTH    = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   input  logic [NUM_REQ*OP_BITS-1:0]  req_op_i,
   input  logic [NUM_REQ*FMT_BITS-1:0] req_fmt_i,
   input  logic [NUM_REQ*3-1:0]        req_rm_i,
   input  logic [NUM_REQ*3*WIDTH-1:0]  req_operands_i,
   output logic                        fpu_valid_o,
   input  logic                        fpu_ready_i,
   output logic [OP_BITS-1:0]          fpu_op_o,
   output logic [FMT_BITS-1:0]         fpu_fmt_o,
   output logic [2:0]                  fpu_rm_o,
   output logic [3*WIDTH-1:0]          fpu_operands_o,
   input  logic                        fpu_resp_valid_i,
   output logic                        fpu_resp_ready_o,
   input  logic [WIDTH-1:0]            fpu_result_i,
   input  logic [4:0]                  fpu_flags_i,
   output logic [NUM_REQ-1:0]          resp_valid_o,
   input  logic [NUM_REQ-1:0]          resp_ready_i,
   output logic [WIDTH-1:0]            resp_result_o,
   output logic [4:0]                  resp_flags_o,
   output logic [$clog2(DEPTH+1)-1:0]  outstanding_o,
   output logic                        busy_o
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH+1);

   localparam logic [IDW:0]   REQ_N   = (IDW+1)'(NUM_REQ);
   localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ-1);
   localparam logic [CW-1:0]  FULL_N  = CW'(DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   gnt_id_q, gnt_id_d;
   logic [IDW-1:0]   rr_q, rr_d;

   logic [IDW-1:0]   fifo_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;

   logic             fifo_full, fifo_empty;
   logic             found;
   logic [IDW-1:0]   cand_id;
   logic [IDW:0]     scan_idx;
   logic [IDW-1:0]   sel_id;
   logic             grant_vld;
   logic             push, pop;
   logic [IDW-1:0]   head_id;

   logic [OP_BITS-1:0]  op_arr  [NUM_REQ];
   logic [FMT_BITS-1:0] fmt_arr [NUM_REQ];
   logic [2:0]          rm_arr  [NUM_REQ];
   logic [3*WIDTH-1:0]  opd_arr [NUM_REQ];

   generate
      for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
         assign op_arr[g]  = req_op_i[g*OP_BITS +: OP_BITS];
         assign fmt_arr[g] = req_fmt_i[g*FMT_BITS +: FMT_BITS];
         assign rm_arr[g]  = req_rm_i[g*3 +: 3];
         assign opd_arr[g] = req_operands_i[g*3*WIDTH +: 3*WIDTH];
      end
   endgenerate

   assign fifo_full  = (count_q == FULL_N);
   assign fifo_empty = (count_q == '0);

   // First valid requester at or above the round-robin pointer, with wrap.
   always_comb begin
      found    = 1'b0;
      cand_id  = rr_q;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = {1'b0, rr_q} + (IDW+1)'(k);
         if (scan_idx >= REQ_N) begin
            scan_idx = scan_idx - REQ_N;
         end
         if (!found && req_valid_i[scan_idx[IDW-1:0]]) begin
            found   = 1'b1;
            cand_id = scan_idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_id_d  = gnt_id_q;
      rr_d      = rr_q;
      sel_id    = (state_q == ST_LOCKED) ? gnt_id_q : cand_id;
      // Fullness uses the registered count, so a pop never frees a slot early.
      grant_vld = !rst && !fifo_full && ((state_q == ST_LOCKED) || found);
      push      = grant_vld && fpu_ready_i;
      if (push) begin
         state_d = ST_IDLE;
         rr_d    = (sel_id == LAST_ID) ? '0 : sel_id + IDW'(1);
      end else if (grant_vld && (state_q == ST_IDLE)) begin
         state_d  = ST_LOCKED;
         gnt_id_d = cand_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         gnt_id_q <= '0;
         rr_q     <= '0;
      end else begin
         state_q  <= state_d;
         gnt_id_q <= gnt_id_d;
         rr_q     <= rr_d;
      end
   end

   assign fpu_valid_o    = grant_vld;
   assign fpu_op_o       = op_arr[sel_id];
   assign fpu_fmt_o      = fmt_arr[sel_id];
   assign fpu_rm_o       = rm_arr[sel_id];
   assign fpu_operands_o = opd_arr[sel_id];

   assign head_id = fifo_q[rd_ptr_q];

   generate
      for (genvar g = 0; g < NUM_REQ; g++) begin : g_route
         assign req_ready_o[g]  = push && (sel_id == IDW'(g));
         assign resp_valid_o[g] = !rst && !fifo_empty && fpu_resp_valid_i
                                  && (head_id == IDW'(g));
      end
   endgenerate

   // With no owner recorded the response is swallowed so the FPU cannot stall.
   assign fpu_resp_ready_o = !rst && (fifo_empty || resp_ready_i[head_id]);
   assign pop              = fpu_resp_valid_i && fpu_resp_ready_o && !fifo_empty;

   assign resp_result_o = fpu_result_i;
   assign resp_flags_o  = fpu_flags_i;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= sel_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign outstanding_o = count_q;
   assign busy_o        = (count_q != '0) || fpu_valid_o;

   a_no_spurious_resp : assert property (
      @(posedge clk) disable iff (rst) !(fpu_resp_valid_i && fifo_empty)
   ) else $error("spurious FPU response with no outstanding operation");

endmodule

`default_nettype wire
